// File: rtl/quad_tick_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quad_tick_decoder
//  Description : Front end for the encoder tick counter. Synchronises and
//                glitch-filters raw A/B quadrature channels, then decodes
//                Gray-code steps into a tick pulse, a toggling tick level,
//                direction and a wrap-around signed position. Illegal double
//                steps raise a sticky error flag instead of counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_tick_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int POS_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 clr_pos,
    output logic                 tick,
    output logic                 tick_lvl,
    output logic                 dir,
    output logic [POS_WIDTH-1:0] position,
    output logic                 err
);

    // Filter counter value on which a persistent new level is accepted.
    localparam logic [7:0] c_filt_last = 8'(FILTER_LEN - 1);

    // Bit 1 is channel A, bit 0 is channel B, so w_filt reads directly as {A,B}.
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {enc_a, enc_b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic       r_sync1;
            logic       r_sync2;
            logic       r_filt;
            logic [7:0] r_cnt;

            // Two-flop synchroniser; runs regardless of ce.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Level filter: a new level must persist FILTER_LEN cycles before it is accepted.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_filt <= 1'b0;
                    r_cnt  <= 8'd0;
                end else if (r_sync2 == r_filt) begin
                    r_cnt <= 8'd0;
                end else if (r_cnt == c_filt_last) begin
                    r_filt <= r_sync2;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic [1:0] r_prev;
    logic       w_fwd;
    logic       w_rev;
    logic       w_ill;
    logic       w_count;

    // Classify the step from the previous filtered state to the current one.
    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        w_ill = 1'b0;
        case ({r_prev, w_filt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_ill = 1'b1;
            default: ;
        endcase
    end

    assign w_count = ce & (w_fwd | w_rev);

    // Previous state tracks the filtered state every cycle so re-enabling ce never counts late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 2'b00;
        end else begin
            r_prev <= w_filt;
        end
    end

    // Tick pulse, tick level and direction follow each counted step; clr_pos does not affect them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick     <= 1'b0;
            tick_lvl <= 1'b0;
            dir      <= 1'b1;
        end else begin
            tick <= w_count;
            if (w_count) begin
                tick_lvl <= ~tick_lvl;
                dir      <= w_fwd;
            end
        end
    end

    // Position wraps modulo 2^POS_WIDTH; a clear on the same edge as a count wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position <= '0;
        end else if (clr_pos) begin
            position <= '0;
        end else if (ce && w_fwd) begin
            position <= position + POS_WIDTH'(1);
        end else if (ce && w_rev) begin
            position <= position - POS_WIDTH'(1);
        end
    end

    // Sticky flag for double-bit steps seen while counting is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr_pos) begin
            err <= 1'b0;
        end else if (ce && w_ill) begin
            err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_tick_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_tick_decoder
//  Description : Self-checking bench for quad_tick_decoder. Expected tick
//                events are queued when a step is driven and checked when the
//                DUT pulses tick; quiescent state is checked against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_tick_decoder;

    localparam int FILTER_LEN = 4;
    localparam int POS_WIDTH  = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 ce;
    logic                 enc_a;
    logic                 enc_b;
    logic                 clr_pos;
    logic                 tick;
    logic                 tick_lvl;
    logic                 dir;
    logic [POS_WIDTH-1:0] position;
    logic                 err;

    quad_tick_decoder #(
        .FILTER_LEN (FILTER_LEN),
        .POS_WIDTH  (POS_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .clr_pos  (clr_pos),
        .tick     (tick),
        .tick_lvl (tick_lvl),
        .dir      (dir),
        .position (position),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                   due;
        logic                 lvl;
        logic                 dir;
        logic [POS_WIDTH-1:0] pos;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model of the decoder outputs.
    logic [1:0]           m_ab  = 2'b11;
    logic [POS_WIDTH-1:0] m_pos = '0;
    logic                 m_lvl = 1'b0;
    logic                 m_dir = 1'b1;
    logic                 m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Position in the forward Gray cycle 00 -> 10 -> 11 -> 01.
    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Drive a new raw level at a negedge; queue the tick it should produce.
    task automatic drive(input logic [1:0] ab, input logic clr_hit);
        int   d;
        exp_t e;
        d = (gidx(ab) - gidx(m_ab) + 4) % 4;
        if (ce && (d == 1 || d == 3)) begin
            m_lvl = ~m_lvl;
            m_dir = (d == 1);
            m_pos = (d == 1) ? m_pos + 1'b1 : m_pos - 1'b1;
            if (clr_hit) begin
                m_pos = '0;
                m_err = 1'b0;
            end
            e.due = cyc + 3 + FILTER_LEN;
            e.lvl = m_lvl;
            e.dir = m_dir;
            e.pos = m_pos;
            q.push_back(e);
        end else if (ce && d == 2) begin
            m_err = 1'b1;
        end
        m_ab  = ab;
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic step(input logic [1:0] ab);
        drive(ab, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_pos = 1'b1;
        @(negedge clk);
        clr_pos = 1'b0;
        m_pos   = '0;
        m_err   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".position"}, 32'(position), 32'(m_pos));
        check({tag, ".err"},      32'(err),      32'(m_err));
        check({tag, ".dir"},      32'(dir),      32'(m_dir));
        check({tag, ".tick_lvl"}, 32'(tick_lvl), 32'(m_lvl));
    endtask

    // Scoreboard: every tick must match the head of the queue, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tick === 1'b1) begin
                if (q.size() == 0) begin
                    check("tick_unexpected", 32'(tick), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("tick_cycle",    32'(cyc),      32'(e.due));
                    check("tick_tick_lvl", 32'(tick_lvl), 32'(e.lvl));
                    check("tick_dir",      32'(dir),      32'(e.dir));
                    check("tick_position", 32'(position), 32'(e.pos));
                end
            end else if (q.size() != 0 && q[0].due < cyc) begin
                check("tick_missing", 32'(tick), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        ce      = 1'b1;
        clr_pos = 1'b0;
        enc_a   = 1'b1;
        enc_b   = 1'b1;

        // Reset values while held in reset with both channels high.
        repeat (3) @(negedge clk);
        check("reset.tick", 32'(tick), 32'd0);
        check_state("reset");

        // First settle sees 00 -> 11: flagged, never counted.
        rst_n = 1'b1;
        m_err = 1'b1;
        repeat (20) @(negedge clk);
        check_state("first_settle");

        // Return to 00 with ce low, then clear.
        ce = 1'b0;
        step(2'b01);
        step(2'b00);
        ce = 1'b1;
        pulse_clr();
        check_state("cleared");

        // Eight forward steps.
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: step(2'b10);
                1: step(2'b11);
                2: step(2'b01);
                default: step(2'b00);
            endcase
        end
        check_state("forward8");

        // Reverse through zero, then forward back.
        pulse_clr();
        step(2'b01);
        step(2'b11);
        step(2'b10);
        check_state("reverse_wrap");
        step(2'b11);
        step(2'b01);
        step(2'b00);
        check_state("forward_unwrap");

        // A 3-cycle glitch on A is rejected.
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (20) @(negedge clk);
        check_state("glitch3");

        // A 4-cycle pulse on A is accepted: one count up, then one down on release.
        drive(2'b10, 1'b0);
        repeat (4) @(negedge clk);
        drive(2'b00, 1'b0);
        repeat (20) @(negedge clk);
        check_state("pulse4");

        // Illegal double step with ce high.
        step(2'b11);
        check_state("illegal");
        pulse_clr();
        check_state("illegal_clr");

        // Steps with ce low are tracked but not counted.
        ce = 1'b0;
        step(2'b01);
        step(2'b00);
        step(2'b10);
        step(2'b11);
        ce = 1'b1;
        repeat (20) @(negedge clk);
        check_state("ce_low");

        // Bring position to 5, then clear on the same edge as the next count.
        step(2'b01);
        step(2'b00);
        step(2'b10);
        step(2'b11);
        step(2'b01);
        check_state("pos5");
        drive(2'b00, 1'b1);
        repeat (2 + FILTER_LEN) @(negedge clk);
        clr_pos = 1'b1;
        @(negedge clk);
        clr_pos = 1'b0;
        repeat (20) @(negedge clk);
        check_state("clr_with_tick");

        // Asynchronous reset mid-operation clears at once.
        step(2'b10);
        check_state("pre_reset");
        rst_n = 1'b0;
        #1;
        m_pos = '0;
        m_lvl = 1'b0;
        m_dir = 1'b1;
        m_err = 1'b0;
        check_state("async_reset");
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
